// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - CAM lookup/insert/delete controller with valid tracking and round-robin eviction
// Optional flush port and logic enabled by defining CAM_FLUSH_EN.
module cam_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_key,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_hit,
    output logic [2:0] resp_addr,
    output logic       resp_evict,
    output logic       cam_we,
    output logic [2:0] cam_waddr,
    output logic [7:0] cam_key,
    input  logic       cam_hit,
    input  logic [2:0] cam_raddr,
    output logic [3:0] occupancy
`ifdef CAM_FLUSH_EN
    ,
    input  logic       flush
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOOK, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] OP_INS = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;

    state_t     state_q, state_d;
    logic [7:0] valid_q, valid_d;
    logic [2:0] rr_q, rr_d;
    logic [1:0] op_q, op_d;
    logic [7:0] key_q, key_d;
    logic [2:0] tgt_q, tgt_d;
    logic       hit_q, hit_d;
    logic [2:0] addr_q, addr_d;
    logic       evict_q, evict_d;
    logic [3:0] occ_q, occ_d;

    logic       qhit;
    logic       has_free;
    logic [2:0] free_idx;
    logic [2:0] ins_slot;
    logic       ins_evict;
    logic       flush_go;

`ifdef CAM_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    assign flush_go = (state_q == S_IDLE) && (flush || flush_pend_q);

    // A flush seen mid-transaction waits until the controller is back in IDLE.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (state_q == S_IDLE)
            flush_pend_d = 1'b0;
        else if (flush)
            flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_pend_q <= 1'b0;
        else        flush_pend_q <= flush_pend_d;
    end
`else
    assign flush_go = 1'b0;
`endif

    assign req_ready  = rst_n && (state_q == S_IDLE) && !flush_go;
    assign resp_valid = (state_q == S_RESP);
    assign resp_hit   = hit_q;
    assign resp_addr  = addr_q;
    assign resp_evict = evict_q;
    assign cam_we     = (state_q == S_WRITE);
    assign cam_waddr  = (state_q == S_WRITE) ? tgt_q : 3'd0;
    assign cam_key    = (state_q == S_LOOK || state_q == S_WRITE) ? key_q : 8'd0;
    assign occupancy  = occ_q;

    assign qhit     = cam_hit && valid_q[cam_raddr];
    assign has_free = ~&valid_q;

    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (!valid_q[i]) free_idx = 3'(i);
    end

    // Stale CAM match is reused first, then the lowest free slot, then eviction.
    always_comb begin
        ins_evict = 1'b0;
        if (cam_hit)
            ins_slot = cam_raddr;
        else if (has_free)
            ins_slot = free_idx;
        else begin
            ins_slot  = rr_q;
            ins_evict = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        op_d    = op_q;
        key_d   = key_q;
        tgt_d   = tgt_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        evict_d = evict_q;
        occ_d   = 4'($countones(valid_q));
        case (state_q)
            S_IDLE: begin
                if (flush_go) begin
                    valid_d = 8'd0;
                    rr_d    = 3'd0;
                end else if (req_valid) begin
                    op_d    = req_op;
                    key_d   = req_key;
                    state_d = S_LOOK;
                end
            end
            S_LOOK: begin
                state_d = S_RESP;
                hit_d   = qhit;
                addr_d  = qhit ? cam_raddr : 3'd0;
                evict_d = 1'b0;
                if (op_q == OP_INS && !qhit) begin
                    hit_d   = 1'b0;
                    tgt_d   = ins_slot;
                    addr_d  = ins_slot;
                    evict_d = ins_evict;
                    state_d = S_WRITE;
                end else if (op_q == OP_DEL && qhit) begin
                    valid_d[cam_raddr] = 1'b0;
                end
            end
            S_WRITE: begin
                valid_d[tgt_q] = 1'b1;
                if (evict_q) rr_d = rr_q + 3'd1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 8'd0;
            rr_q    <= 3'd0;
            op_q    <= 2'd0;
            key_q   <= 8'd0;
            tgt_q   <= 3'd0;
            hit_q   <= 1'b0;
            addr_q  <= 3'd0;
            evict_q <= 1'b0;
            occ_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            key_q   <= key_d;
            tgt_q   <= tgt_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
            evict_q <= evict_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - randomized self-checking bench for cam_ctrl against a slot-level CAM model
// Flush scenario is compiled in when CAM_FLUSH_EN is defined.
module tb_cam_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_key = 8'd0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic       resp_hit;
    logic [2:0] resp_addr;
    logic       resp_evict;
    logic       cam_we;
    logic [2:0] cam_waddr;
    logic [7:0] cam_key;
    logic       cam_hit;
    logic [2:0] cam_raddr;
    logic [3:0] occupancy;
`ifdef CAM_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;

    logic [7:0] cam_mem [8] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};

    logic [7:0] m_key [8] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
    bit         m_valid [8];
    int         m_rr = 0;

    always #5 clk = ~clk;

    cam_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_addr(resp_addr), .resp_evict(resp_evict),
        .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_key(cam_key),
        .cam_hit(cam_hit), .cam_raddr(cam_raddr),
        .occupancy(occupancy)
`ifdef CAM_FLUSH_EN
        , .flush(flush)
`endif
    );

    always_comb begin
        cam_hit   = 1'b0;
        cam_raddr = 3'd0;
        for (int i = 0; i < 8; i++)
            if (cam_mem[i] == cam_key) begin
                cam_hit   = 1'b1;
                cam_raddr = 3'(i);
            end
    end

    always @(posedge clk) if (cam_we) cam_mem[cam_waddr] <= cam_key;

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic model_req(input logic [1:0] op, input logic [7:0] key,
                             output logic hit, output logic [2:0] addr,
                             output logic evict, output int lat);
        int idx, tgt;
        bit qh;
        idx = -1;
        for (int i = 0; i < 8; i++) if (m_key[i] == key) idx = i;
        qh = (idx >= 0) && m_valid[idx];
        hit = 1'b0; addr = 3'd0; evict = 1'b0; lat = 2;
        if (op == 2'b01) begin
            if (qh) begin
                hit = 1'b1; addr = 3'(idx);
            end else begin
                tgt = idx;
                if (tgt < 0)
                    for (int i = 7; i >= 0; i--) if (!m_valid[i]) tgt = i;
                if (tgt < 0) begin
                    tgt = m_rr; evict = 1'b1; m_rr = (m_rr + 1) % 8;
                end
                m_key[tgt] = key; m_valid[tgt] = 1'b1; addr = 3'(tgt); lat = 3;
            end
        end else if (op == 2'b10) begin
            if (qh) begin
                m_valid[idx] = 1'b0; hit = 1'b1; addr = 3'(idx);
            end
        end else if (qh) begin
            hit = 1'b1; addr = 3'(idx);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] key, input int hold,
                          output logic hit, output logic [2:0] addr, output logic evict,
                          output int lat, output bit stable, output bit rdy_low);
        int guard = 0;
        stable = 1'b1; rdy_low = 1'b1;
        resp_ready = (hold == 0);
        req_valid = 1'b1; req_op = op; req_key = key;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 30) begin @(negedge clk); lat++; end
        hit = resp_hit; addr = resp_addr; evict = resp_evict;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_hit !== hit || resp_addr !== addr || resp_evict !== evict)
                stable = 1'b0;
            if (req_ready !== 1'b0) rdy_low = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_clear();
        #1;
        nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        nvec++; if ({resp_valid, resp_hit, resp_addr, resp_evict} !== 6'd0) begin nerr++; $display("FAIL reset_resp: got %b want 000000", {resp_valid, resp_hit, resp_addr, resp_evict}); end
        nvec++; if ({cam_we, cam_waddr, cam_key} !== 12'd0) begin nerr++; $display("FAIL reset_cam: got %h want 000", {cam_we, cam_waddr, cam_key}); end
        nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_lookup_empty();
        logic h, e; logic [2:0] a; int l; bit s, r;
        do_req(2'b00, 8'h5A, 0, h, a, e, l, s, r);
        nvec++; if ({h, a} !== 4'd0) begin nerr++; $display("FAIL empty_lookup: got hit=%b addr=%0d want 0/0", h, a); end
        nvec++; if (l !== 2) begin nerr++; $display("FAIL empty_lookup_lat: got %0d want 2", l); end
        nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL empty_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_insert_seq();
        logic [7:0] keys [3] = '{8'h11, 8'h22, 8'h33};
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        for (int i = 0; i < 3; i++) begin
            model_req(2'b01, keys[i], mh, ma, me, ml);
            do_req(2'b01, keys[i], 0, h, a, e, l, s, r);
            nvec++; if ({h, a, e} !== {1'b0, 3'(i), 1'b0}) begin nerr++; $display("FAIL insert_seq[%0d]: got hit=%b addr=%0d ev=%b want 0/%0d/0", i, h, a, e, i); end
            nvec++; if (l !== 3) begin nerr++; $display("FAIL insert_seq_lat[%0d]: got %0d want 3", i, l); end
        end
        nvec++; if (occupancy !== 4'd3) begin nerr++; $display("FAIL insert_seq_occ: got %0d want 3", occupancy); end
        model_req(2'b00, 8'h22, mh, ma, me, ml);
        do_req(2'b00, 8'h22, 0, h, a, e, l, s, r);
        nvec++; if ({h, a} !== {1'b1, 3'd1}) begin nerr++; $display("FAIL lookup_22: got hit=%b addr=%0d want 1/1", h, a); end
    endtask

    task automatic test_evict();
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            model_req(2'b01, 8'h80 + 8'(i), mh, ma, me, ml);
            do_req(2'b01, 8'h80 + 8'(i), 0, h, a, e, l, s, r);
        end
        nvec++; if (occupancy !== 4'd8) begin nerr++; $display("FAIL evict_full_occ: got %0d want 8", occupancy); end
        model_req(2'b01, 8'h99, mh, ma, me, ml);
        do_req(2'b01, 8'h99, 0, h, a, e, l, s, r);
        nvec++; if ({e, a} !== {1'b1, 3'd0}) begin nerr++; $display("FAIL evict_first: got ev=%b addr=%0d want 1/0", e, a); end
        for (int i = 0; i < 9; i++) begin
            model_req(2'b01, 8'hA0 + 8'(i), mh, ma, me, ml);
            do_req(2'b01, 8'hA0 + 8'(i), 0, h, a, e, l, s, r);
            nvec++; if ({h, a, e} !== {mh, ma, me}) begin nerr++; $display("FAIL evict_wrap[%0d]: got %b/%0d/%b want %b/%0d/%b", i, h, a, e, mh, ma, me); end
        end
        nvec++; if (a !== 3'd1) begin nerr++; $display("FAIL evict_rr_wrap: got %0d want 1", a); end
    endtask

    task automatic test_delete_reuse();
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            model_req(2'b01, 8'h01 + 8'(i), mh, ma, me, ml);
            do_req(2'b01, 8'h01 + 8'(i), 0, h, a, e, l, s, r);
        end
        model_req(2'b01, 8'h44, mh, ma, me, ml);
        do_req(2'b01, 8'h44, 0, h, a, e, l, s, r);
        nvec++; if (a !== 3'd3) begin nerr++; $display("FAIL del_setup_slot: got %0d want 3", a); end
        model_req(2'b10, 8'h44, mh, ma, me, ml);
        do_req(2'b10, 8'h44, 0, h, a, e, l, s, r);
        nvec++; if ({h, a} !== {1'b1, 3'd3}) begin nerr++; $display("FAIL delete_hit: got hit=%b addr=%0d want 1/3", h, a); end
        nvec++; if (occupancy !== 4'd3) begin nerr++; $display("FAIL delete_occ: got %0d want 3", occupancy); end
        model_req(2'b10, 8'h44, mh, ma, me, ml);
        do_req(2'b10, 8'h44, 0, h, a, e, l, s, r);
        nvec++; if ({h, a, occupancy} !== {1'b0, 3'd0, 4'd3}) begin nerr++; $display("FAIL delete_miss: got hit=%b addr=%0d occ=%0d want 0/0/3", h, a, occupancy); end
        model_req(2'b01, 8'h44, mh, ma, me, ml);
        do_req(2'b01, 8'h44, 0, h, a, e, l, s, r);
        nvec++; if ({h, a} !== {1'b0, 3'd3}) begin nerr++; $display("FAIL reinsert_slot: got hit=%b addr=%0d want 0/3", h, a); end
    endtask

    task automatic test_backpressure();
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        model_req(2'b01, 8'h6B, mh, ma, me, ml);
        do_req(2'b01, 8'h6B, 5, h, a, e, l, s, r);
        nvec++; if ({h, a, e} !== {mh, ma, me}) begin nerr++; $display("FAIL bp_resp: got %b/%0d/%b want %b/%0d/%b", h, a, e, mh, ma, me); end
        nvec++; if (s !== 1'b1) begin nerr++; $display("FAIL bp_stable: got %b want 1", s); end
        nvec++; if (r !== 1'b1) begin nerr++; $display("FAIL bp_req_ready_low: got %b want 1", r); end
    endtask

    task automatic test_reset_in_write();
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_key = 8'hC3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nvec++; if (cam_we !== 1'b1) begin nerr++; $display("FAIL write_state_we: got %b want 1", cam_we); end
        rst_n = 1'b0;
        m_clear();
        #1;
        nvec++; if ({cam_we, resp_valid, req_ready} !== 3'b000) begin nerr++; $display("FAIL rst_in_write: got we/rv/rr=%b want 000", {cam_we, resp_valid, req_ready}); end
        nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL rst_in_write_occ: got %0d want 0", occupancy); end
        @(negedge clk);
        rst_n = 1'b1;
        model_req(2'b00, 8'hC3, mh, ma, me, ml);
        do_req(2'b00, 8'hC3, 0, h, a, e, l, s, r);
        nvec++; if ({h, a} !== {mh, ma}) begin nerr++; $display("FAIL post_rst_lookup: got %b/%0d want %b/%0d", h, a, mh, ma); end
    endtask

    task automatic test_random();
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        logic [1:0] op; logic [7:0] key; int sel, hold;
        for (int n = 0; n < 80; n++) begin
            sel  = $urandom_range(0, 9);
            op   = (sel < 5) ? 2'b01 : (sel < 7) ? 2'b10 : (sel < 9) ? 2'b00 : 2'b11;
            key  = 8'($urandom_range(0, 11));
            hold = $urandom_range(0, 2);
            model_req(op, key, mh, ma, me, ml);
            do_req(op, key, hold, h, a, e, l, s, r);
            nvec++; if ({h, a, e} !== {mh, ma, me}) begin nerr++; $display("FAIL rand[%0d] op=%0d key=%h: got %b/%0d/%b want %b/%0d/%b", n, op, key, h, a, e, mh, ma, me); end
            nvec++; if (l !== ml) begin nerr++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, l, ml); end
            nvec++; if (int'(occupancy) !== m_occ()) begin nerr++; $display("FAIL rand_occ[%0d]: got %0d want %0d", n, occupancy, m_occ()); end
        end
    endtask

`ifdef CAM_FLUSH_EN
    task automatic test_flush();
        logic [7:0] keys [4] = '{8'h71, 8'h72, 8'h73, 8'h74};
        logic h, e, mh, me; logic [2:0] a, ma; int l, ml; bit s, r;
        for (int i = 0; i < 4; i++) begin
            model_req(2'b01, keys[i], mh, ma, me, ml);
            do_req(2'b01, keys[i], 0, h, a, e, l, s, r);
        end
        flush = 1'b1;
        #1;
        nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        @(negedge clk);
        flush = 1'b0;
        m_clear();
        @(negedge clk);
        nvec++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        for (int i = 0; i < 4; i++) begin
            model_req(2'b00, keys[i], mh, ma, me, ml);
            do_req(2'b00, keys[i], 0, h, a, e, l, s, r);
            nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL flush_lookup[%0d]: got hit=%b want 0", i, h); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lookup_empty();
        test_insert_seq();
        test_evict();
        test_delete_reuse();
        test_backpressure();
        test_reset_in_write();
        test_random();
`ifdef CAM_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
